// File: rtl/rf_spreader_tx.sv
// Serial spreading transmitter: maps 4-bit symbols to 32-bit codewords and shifts them out MSB-first.
// A one-deep holding register lets consecutive frames run with no idle bits between them.
module rf_spreader_tx #(
  parameter int   CODE_W   = 32,
  parameter int   SYM_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [SYM_W-1:0]  Sym_in,
  input  logic              Sym_valid,
  output logic              Sym_ready,
  input  logic              Cb_we,
  input  logic [SYM_W-1:0]  Cb_addr,
  input  logic [CODE_W-1:0] Cb_data,
  output logic              Bit_stream,
  output logic              Frame_start,
  output logic              Busy
);

  localparam int NENT  = 2 ** SYM_W;
  localparam int CNT_W = $clog2(CODE_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CODE_W - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] shreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SYM_W-1:0]  hold_sym_q;
  logic              hold_valid_q;
  logic              bit_q;
  logic              fs_q;
  logic [CODE_W-1:0] cb [NENT];

  logic              xfer;
  logic              load;
  logic              hold_set;
  logic              hold_clr;
  logic [SYM_W-1:0]  load_sym;
  logic [CODE_W-1:0] cw;

  assign Sym_ready   = !hold_valid_q;
  assign xfer        = Sym_valid && !hold_valid_q;
  assign Bit_stream  = bit_q;
  assign Frame_start = fs_q;
  assign Busy        = (state_q == SEND);

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    hold_set = 1'b0;
    hold_clr = 1'b0;
    load_sym = Sym_in;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (cnt_q == LAST) begin
          if (hold_valid_q) begin
            load     = 1'b1;
            load_sym = hold_sym_q;
            hold_clr = 1'b1;
          end else if (xfer) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          hold_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cw = cb[load_sym];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      hold_sym_q   <= '0;
      hold_valid_q <= 1'b0;
      bit_q        <= IDLE_BIT;
      fs_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hold_set) begin
        hold_sym_q   <= Sym_in;
        hold_valid_q <= 1'b1;
      end else if (hold_clr) begin
        hold_valid_q <= 1'b0;
      end
      // bit_q always carries the chip on the wire; shreg_q holds the chips still to come.
      if (load) begin
        bit_q   <= cw[CODE_W-1];
        shreg_q <= {cw[CODE_W-2:0], 1'b0};
        cnt_q   <= '0;
        fs_q    <= 1'b1;
      end else if (state_d == SEND) begin
        bit_q   <= shreg_q[CODE_W-1];
        shreg_q <= {shreg_q[CODE_W-2:0], 1'b0};
        cnt_q   <= cnt_q + 1'b1;
        fs_q    <= 1'b0;
      end else begin
        bit_q <= IDLE_BIT;
        fs_q  <= 1'b0;
      end
    end
  end

  // Codebook: loads read the pre-write value when write and load hit the same entry.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NENT; i++) begin
        if (i == 0)
          cb[i] <= CODE_W'(32'hFBDD_7EDF);
        else if (i == NENT - 1)
          cb[i] <= '0;
        else
          cb[i] <= '1;
      end
    end else if (Cb_we) begin
      cb[Cb_addr] <= Cb_data;
    end
  end

endmodule

// File: doc/rf_spreader_tx.md
Name: rf_spreader_tx

Overview:
Transmit-side counterpart of the RF correlator. It accepts 4-bit symbols over a valid/ready handshake, maps each symbol to a 32-bit spreading codeword from a runtime-writable codebook, and shifts the codeword out MSB-first, one bit per Clock. Bit order matches the correlator's left-shifting deserializer, so the first transmitted bit lands in bit 31 of the received word. A one-deep holding register allows back-to-back frames with no idle bits between them.

Parameters:
CODE_W, 32, codeword length in bits; also the serial frame length in clocks.
SYM_W, 4, symbol width; the codebook has 2**SYM_W entries.
IDLE_BIT, 1'b0, Bit_stream level driven while no frame is being sent.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
Sym_in  input  SYM_W  symbol to transmit.
Sym_valid  input  1  Sym_in is valid.
Sym_ready  output  1  block can accept a symbol this cycle.
Cb_we  input  1  codebook write enable.
Cb_addr  input  SYM_W  codebook entry index.
Cb_data  input  CODE_W  codeword to write.
Bit_stream  output  1  serial chip output; registered.
Frame_start  output  1  high while bit CODE_W-1 of a frame is on Bit_stream.
Busy  output  1  high while a frame is being shifted out.

Behaviour:
- Reset (asynchronous): state=IDLE; shift register, bit counter and holding register cleared; hold_valid=0; Bit_stream=IDLE_BIT; Frame_start=0; Busy=0. Codebook loads its default contents:
  - entry 0 = 32'hFBDD_7EDF
  - entries 1..14 = 32'hFFFF_FFFF
  - entry 15 = 32'h0000_0000
- Reset mid-frame aborts the frame immediately and drops any held symbol.
- Handshake:
  - Sym_ready = !hold_valid (combinational from a register).
  - A transfer occurs on a rising edge where Sym_valid && Sym_ready.
  - Sym_in is ignored when no transfer occurs.
- Holding register: an accepted symbol is written to hold_sym and hold_valid is set. Exception: in IDLE the symbol is loaded straight into the shifter (see below) and hold_valid stays 0.
- FSM:
  - IDLE: Bit_stream=IDLE_BIT, Busy=0. On a transfer at edge k: shreg <= codebook[Sym_in], cnt <= 0, state <= SEND. At edge k, Bit_stream takes the codeword MSB, Frame_start=1 and Busy=1, all visible in cycle k+1 (one-clock latency).
  - SEND: on each edge, cnt increments and the shifter moves left, so Bit_stream follows codeword bits CODE_W-1 down to 0 over 32 consecutive cycles. Frame_start=0 after the first cycle.
  - End of frame (edge where cnt==CODE_W-1):
    - If hold_valid=1: load codebook[hold_sym], clear hold_valid, cnt <= 0, Frame_start=1, stay in SEND. There is no gap bit.
    - Else, if a transfer occurs on that same edge: load the incoming symbol directly, stay in SEND.
    - Else: go to IDLE; Bit_stream returns to IDLE_BIT.
- Simultaneous hold release and a new transfer cannot happen, because Sym_ready=0 whenever hold_valid=1.
- Codebook:
  - 2**SYM_W x CODE_W registers with a synchronous write on Cb_we.
  - A codeword is copied into the shifter at load time, so a write never alters a frame already in flight.
  - A write and a load of the same entry on the same edge: the load uses the old value; the new value applies from the next load.
  - Writes are accepted in any state.
- Widths: cnt is clog2(CODE_W) bits; no arithmetic beyond the counter increment.
- Throughput: one symbol per CODE_W clocks sustained. With default parameters the frame boundaries align with the correlator's 32-clock word when both leave reset on the same edge and the first symbol is presented in the first cycle after reset.

Test Plan:
- Reset, then hold Sym_valid=1, Sym_in=0 for one transfer → Frame_start=1 one cycle later; Bit_stream carries 0xFBDD_7EDF MSB-first over 32 cycles; then Bit_stream=0 and Busy=0.
- Present symbols 0, 15, 3 back-to-back with Sym_valid held → exactly 96 contiguous bits (0xFBDD7EDF, 0x00000000, 0xFFFFFFFF); Frame_start pulses every 32 cycles; Sym_ready=0 whenever a symbol is held.
- Write Cb_addr=5, Cb_data=0xA5A5_0F0F, then send symbol 5 → serial output 0xA5A5_0F0F. Rewrite entry 5 mid-frame → the current frame is unchanged and the next frame of symbol 5 uses the new word.
- Assert Reset at bit 10 of a frame while a symbol is held → outputs return to their reset values immediately; the held symbol is not sent; the codebook reverts to its defaults.
- Hold Sym_valid=0 for 50 cycles after a frame → Bit_stream=IDLE_BIT and Busy=0 throughout; then a transfer restarts with the one-cycle latency.
- Loopback into the RF correlator with symbol 0 every 32 clocks from reset → correlator Out_str=0 for each frame.
